histogram_readout: RTL

Readout engine for the histogram memory block. On a start pulse it takes the histogram out of acquisition mode, sweeps every bin address from 0 to 2^ADDR_W−1 and captures each count. It streams the counts out over a valid/ready interface tagged with bin index and last flag, and optionally pulses the histogram's clear afterwards. It sits between the histogram's rw/addr/data_out/rst port group and the downstream transport (DMA/UART/PS bridge).

---
 rtl/histogram_readout.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/histogram_readout.sv
// Histogram readout engine: sweeps every bin, streams counts over valid/ready,
// and can pulse the histogram clear once the last bin has been delivered.
module histogram_readout #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 2,
    parameter int CLR_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] hist_addr,
    output logic              hist_rw,
    input  logic [DATA_W-1:0] hist_data,
    output logic              hist_rst,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_bin,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, WAIT, OUT, CLEAR} state_t;

    localparam logic [2:0]        WAIT_LAST = 3'(RD_LAT - 1);
    localparam logic [3:0]        CLR_LAST  = 4'(CLR_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rw_reg, rw_next;
    logic              hrst_reg, hrst_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] bin_reg, bin_next;
    logic              last_reg, last_next;
    logic              valid_reg, valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              clr_en_reg, clr_en_next;
    logic [2:0]        wait_cnt_reg, wait_cnt_next;
    logic [3:0]        clr_cnt_reg, clr_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            rw_reg       <= 1'b0;
            hrst_reg     <= 1'b0;
            data_reg     <= '0;
            bin_reg      <= '0;
            last_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            clr_en_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            clr_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rw_reg       <= rw_next;
            hrst_reg     <= hrst_next;
            data_reg     <= data_next;
            bin_reg      <= bin_next;
            last_reg     <= last_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            clr_en_reg   <= clr_en_next;
            wait_cnt_reg <= wait_cnt_next;
            clr_cnt_reg  <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        rw_next       = rw_reg;
        hrst_next     = hrst_reg;
        data_next     = data_reg;
        bin_next      = bin_reg;
        last_next     = last_reg;
        valid_next    = valid_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        clr_en_next   = clr_en_reg;
        wait_cnt_next = wait_cnt_reg;
        clr_cnt_next  = clr_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = WAIT;
                    addr_next     = '0;
                    rw_next       = 1'b1;
                    busy_next     = 1'b1;
                    clr_en_next   = clear_en;
                    wait_cnt_next = '0;
                end
            end
            WAIT: begin
                // Capture on the RD_LAT-th edge after the address was presented.
                if (wait_cnt_reg == WAIT_LAST) begin
                    data_next  = hist_data;
                    bin_next   = addr_reg;
                    last_next  = (addr_reg == ADDR_MAX);
                    valid_next = 1'b1;
                    state_next = OUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end
            OUT: begin
                if (valid_reg && m_ready) begin
                    valid_next = 1'b0;
                    if (!last_reg) begin
                        addr_next     = addr_reg + 1'b1;
                        wait_cnt_next = '0;
                        state_next    = WAIT;
                    end else if (clr_en_reg) begin
                        hrst_next    = 1'b1;
                        clr_cnt_next = '0;
                        state_next   = CLEAR;
                    end else begin
                        rw_next    = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    hrst_next  = 1'b0;
                    rw_next    = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over any handshake or clear in the same cycle.
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            valid_next = 1'b0;
            hrst_next  = 1'b0;
            rw_next    = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
        end
    end

    assign hist_addr = addr_reg;
    assign hist_rw   = rw_reg;
    assign hist_rst  = hrst_reg;
    assign m_data    = data_reg;
    assign m_bin     = bin_reg;
    assign m_last    = last_reg;
    assign m_valid   = valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
